// File: rtl/alu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct constants and immediate helpers.
package alu_pkg;

  // ALU control codes (GT is reserved: listed for the ALU, never emitted by decode)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_GT  = 4'b0111;
  localparam logic [3:0] ALU_LT  = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1001;

  // Major opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction -> ALU control slice decoder.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_control,
  output logic [4:0]  shift_amount,
  output logic        use_imm,
  output logic [31:0] imm_ext,
  output logic [4:0]  dest_reg,
  output logic        reg_write,
  output logic        illegal
);

  logic [5:0]  op_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;
  logic        unused_rs_s;

  assign op_s    = instr[31:26];
  assign rt_s    = instr[20:16];
  assign rd_s    = instr[15:11];
  assign shamt_s = instr[10:6];
  assign funct_s = instr[5:0];
  assign imm_s   = instr[15:0];
  // rs only selects an operand register upstream; it never changes the control encoding
  assign unused_rs_s = &{1'b0, instr[25:21]};

  logic [3:0]  alu_s;
  logic [4:0]  sh_s;
  logic        use_imm_s;
  logic [31:0] imm_ext_s;
  logic [4:0]  dest_s;
  logic        wr_s;
  logic        ill_s;

  // Raw per-opcode decode; write enable here ignores the $zero destination rule
  always_comb begin
    alu_s     = ALU_ADD;
    sh_s      = 5'd0;
    use_imm_s = 1'b0;
    imm_ext_s = 32'd0;
    dest_s    = 5'd0;
    wr_s      = 1'b0;
    ill_s     = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        dest_s = rd_s;
        wr_s   = 1'b1;
        case (funct_s)
          F_ADD, F_ADDU: alu_s = ALU_ADD;
          F_SUB, F_SUBU: alu_s = ALU_SUB;
          F_AND:         alu_s = ALU_AND;
          F_OR:          alu_s = ALU_OR;
          F_NOR:         alu_s = ALU_NOR;
          F_SLT:         alu_s = ALU_LT;
          F_SLL: begin alu_s = ALU_SLL; sh_s = shamt_s; end
          F_SRL: begin alu_s = ALU_SRL; sh_s = shamt_s; end
          F_SRA: begin alu_s = ALU_SRA; sh_s = shamt_s; end
          default:       ill_s = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        alu_s = ALU_ADD; use_imm_s = 1'b1; imm_ext_s = sign_ext16(imm_s);
        dest_s = rt_s; wr_s = 1'b1;
      end
      OP_SLTI: begin
        alu_s = ALU_LT; use_imm_s = 1'b1; imm_ext_s = sign_ext16(imm_s);
        dest_s = rt_s; wr_s = 1'b1;
      end
      OP_ANDI: begin
        alu_s = ALU_AND; use_imm_s = 1'b1; imm_ext_s = zero_ext16(imm_s);
        dest_s = rt_s; wr_s = 1'b1;
      end
      OP_ORI: begin
        alu_s = ALU_OR; use_imm_s = 1'b1; imm_ext_s = zero_ext16(imm_s);
        dest_s = rt_s; wr_s = 1'b1;
      end
      OP_SW: begin
        alu_s = ALU_ADD; use_imm_s = 1'b1; imm_ext_s = sign_ext16(imm_s);
        dest_s = rt_s; wr_s = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        // compare rs against rt register; immediate is only the branch offset
        alu_s = ALU_SUB; use_imm_s = 1'b0; imm_ext_s = sign_ext16(imm_s);
        dest_s = rt_s; wr_s = 1'b0;
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Final slice: illegal words collapse to a neutral ADD, and $zero never gets written
  always_comb begin
    if (ill_s) begin
      alu_control  = ALU_ADD;
      shift_amount = 5'd0;
      use_imm      = 1'b0;
      imm_ext      = 32'd0;
      dest_reg     = 5'd0;
      reg_write    = 1'b0;
      illegal      = 1'b1;
    end else begin
      alu_control  = alu_s;
      shift_amount = sh_s;
      use_imm      = use_imm_s;
      imm_ext      = imm_ext_s;
      dest_reg     = dest_s;
      reg_write    = wr_s & (dest_s != 5'd0);
      illegal      = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_encode_stage.sv
// ID/EX control-slice register with stall/flush handling and a saturating illegal counter.
module alu_ctrl_encode_stage
  import alu_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          instr,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [3:0]           alu_control,
  output logic [4:0]           shift_amount,
  output logic                 use_imm,
  output logic [31:0]          imm_ext,
  output logic [4:0]           dest_reg,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [ILL_CNT_W-1:0] CNT_MAX = {ILL_CNT_W{1'b1}};
  localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]  dec_alu_s;
  logic [4:0]  dec_sh_s;
  logic        dec_use_imm_s;
  logic [31:0] dec_imm_s;
  logic [4:0]  dec_dest_s;
  logic        dec_wr_s;
  logic        dec_ill_s;

  alu_op_decode u_decode (
    .instr        (instr),
    .alu_control  (dec_alu_s),
    .shift_amount (dec_sh_s),
    .use_imm      (dec_use_imm_s),
    .imm_ext      (dec_imm_s),
    .dest_reg     (dec_dest_s),
    .reg_write    (dec_wr_s),
    .illegal      (dec_ill_s)
  );

  logic                 ex_valid_d,  ex_valid_q;
  logic [3:0]           alu_ctrl_d,  alu_ctrl_q;
  logic [4:0]           shamt_d,     shamt_q;
  logic                 use_imm_d,   use_imm_q;
  logic [31:0]          imm_ext_d,   imm_ext_q;
  logic [4:0]           dest_d,      dest_q;
  logic                 reg_write_d, reg_write_q;
  logic                 illegal_d,   illegal_q;
  logic [ILL_CNT_W-1:0] ill_cnt_d,   ill_cnt_q;

  // Next-state select: flush (or an empty ID slot) bubbles, stall holds, otherwise load decode
  always_comb begin
    ex_valid_d  = ex_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    shamt_d     = shamt_q;
    use_imm_d   = use_imm_q;
    imm_ext_d   = imm_ext_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    ill_cnt_d   = ill_cnt_q;
    if (flush || (!stall && !id_valid)) begin
      ex_valid_d  = 1'b0;
      alu_ctrl_d  = ALU_ADD;
      shamt_d     = 5'd0;
      use_imm_d   = 1'b0;
      imm_ext_d   = 32'd0;
      dest_d      = 5'd0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (stall) begin
      ex_valid_d  = ex_valid_q;
    end else begin
      ex_valid_d  = ~dec_ill_s;
      alu_ctrl_d  = dec_alu_s;
      shamt_d     = dec_sh_s;
      use_imm_d   = dec_use_imm_s;
      imm_ext_d   = dec_imm_s;
      dest_d      = dec_dest_s;
      reg_write_d = dec_wr_s;
      illegal_d   = dec_ill_s;
      if (dec_ill_s && (ill_cnt_q != CNT_MAX)) begin
        ill_cnt_d = ill_cnt_q + CNT_ONE;
      end else begin
        ill_cnt_d = ill_cnt_q;
      end
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      alu_ctrl_q  <= ALU_ADD;
      shamt_q     <= 5'd0;
      use_imm_q   <= 1'b0;
      imm_ext_q   <= 32'd0;
      dest_q      <= 5'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      ill_cnt_q   <= {ILL_CNT_W{1'b0}};
    end else begin
      ex_valid_q  <= ex_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      shamt_q     <= shamt_d;
      use_imm_q   <= use_imm_d;
      imm_ext_q   <= imm_ext_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign alu_control  = alu_ctrl_q;
  assign shift_amount = shamt_q;
  assign use_imm      = use_imm_q;
  assign imm_ext      = imm_ext_q;
  assign dest_reg     = dest_q;
  assign reg_write    = reg_write_q;
  assign illegal      = illegal_q;
  assign ill_count    = ill_cnt_q;

endmodule
